// File: rtl/h264enc_gm_pkg.sv
// Shared constants and FSM encoding for the encoder generic-master arbiter.
package h264enc_gm_pkg;

  localparam logic [1:0] GM_BURST_INCR = 2'b01;
  localparam logic [3:0] GM_CACHE      = 4'b0011;
  localparam logic [2:0] GM_PROT       = 3'b000;
  localparam logic [2:0] GM_SIZE_64    = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2
  } gm_state_e;

endpackage

// File: rtl/h264enc_gm_arbiter_rr_pick.sv
// Circular priority picker: first set request at or after rr_ptr.
module gm_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [IDXW-1:0]    pick_idx,
  output logic               pick_any
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[IDXW'(cand)]) begin
        pick_idx = IDXW'(cand);
        pick_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/h264enc_gm_arbiter.sv
// Round-robin arbiter sharing the DW_axi_gm command/data port between encoder
// DMA requesters; write bursts hold the grant, read data is routed by gm_sid.
//
// state    | meaning
// ST_IDLE  | no grant; pick next requester round-robin
// ST_CMD   | command of gnt_idx presented to the bridge
// ST_WDATA | remaining write beats of gnt_idx; grant locked
module h264enc_gm_arbiter
  import h264enc_gm_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int AXI_DW   = 64,
  parameter int AXI_AW   = 32,
  parameter int AXI_MIDW = 4
) (
  input  logic                        axi_clk,
  input  logic                        axi_rstn,
  input  logic [NUM_REQ-1:0]          req_mread,
  input  logic [NUM_REQ-1:0]          req_mwrite,
  input  logic [NUM_REQ*AXI_AW-1:0]   req_maddr,
  input  logic [NUM_REQ*4-1:0]        req_mlen,
  input  logic [NUM_REQ*AXI_DW-1:0]   req_mdata,
  input  logic [NUM_REQ*AXI_DW/8-1:0] req_mwstrb,
  output logic [NUM_REQ-1:0]          req_saccept,
  output logic [NUM_REQ-1:0]          rsp_svalid,
  output logic [AXI_DW-1:0]           rsp_sdata,
  output logic                        rsp_slast,
  output logic [2:0]                  rsp_sresp,
  input  logic [NUM_REQ-1:0]          rsp_mready,
  output logic [AXI_AW-1:0]           gm_maddr,
  output logic [3:0]                  gm_mlen,
  output logic [AXI_DW-1:0]           gm_mdata,
  output logic [AXI_DW/8-1:0]         gm_mwstrb,
  output logic [AXI_MIDW-1:0]         gm_mid,
  output logic                        gm_mread,
  output logic                        gm_mwrite,
  output logic [1:0]                  gm_mburst,
  output logic [3:0]                  gm_mcache,
  output logic [2:0]                  gm_mprot,
  output logic [2:0]                  gm_msize,
  output logic                        gm_mlock,
  output logic                        gm_mready,
  input  logic                        gm_saccept,
  input  logic                        gm_svalid,
  input  logic                        gm_slast,
  input  logic [AXI_DW-1:0]           gm_sdata,
  input  logic [2:0]                  gm_sresp,
  input  logic [AXI_MIDW-1:0]         gm_sid,
  output logic                        err_sid
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int SW   = AXI_DW / 8;

  gm_state_e         state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic              err_sid_q, err_sid_d;

  logic [NUM_REQ-1:0] req_any;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_any;

  logic              sel_rd, sel_wr;
  logic [AXI_AW-1:0] sel_addr;
  logic [3:0]        sel_len;
  logic [AXI_DW-1:0] sel_data;
  logic [SW-1:0]     sel_strb;
  logic [IDXW-1:0]   gnt_next;
  logic              sid_bad;

  assign req_any = req_mread | req_mwrite;

  gm_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req      (req_any),
    .rr_ptr   (rr_ptr_q),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_comb begin
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_q == IDXW'(i)) begin
        sel_rd   = req_mread[i];
        sel_wr   = req_mwrite[i];
        sel_addr = req_maddr[i*AXI_AW +: AXI_AW];
        sel_len  = req_mlen[i*4 +: 4];
        sel_data = req_mdata[i*AXI_DW +: AXI_DW];
        sel_strb = req_mwstrb[i*SW +: SW];
      end
    end
  end

  assign gnt_next = (gnt_idx_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      err_sid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      err_sid_q  <= err_sid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    err_sid_d  = err_sid_q | (gm_svalid & sid_bad);
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (gm_saccept) begin
          rr_ptr_d = gnt_next;
          addr_d   = sel_addr;
          len_d    = sel_len;
          // A request with both bits set is a write.
          if (sel_wr && (sel_len != 4'd0)) begin
            beat_cnt_d = sel_len;
            state_d    = ST_WDATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WDATA: begin
        if (gm_saccept) begin
          beat_cnt_d = beat_cnt_q - 4'd1;
          if (beat_cnt_q == 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gm_mread    = 1'b0;
    gm_mwrite   = 1'b0;
    gm_maddr    = '0;
    gm_mlen     = '0;
    gm_mdata    = '0;
    gm_mwstrb   = '0;
    gm_mid      = '0;
    req_saccept = '0;
    unique case (state_q)
      ST_CMD: begin
        gm_mwrite = sel_wr;
        gm_mread  = sel_rd & ~sel_wr;
        gm_maddr  = sel_addr;
        gm_mlen   = sel_len;
        gm_mdata  = sel_data;
        gm_mwstrb = sel_strb;
        gm_mid    = AXI_MIDW'(gnt_idx_q);
      end
      ST_WDATA: begin
        gm_mwrite = 1'b1;
        gm_maddr  = addr_q;
        gm_mlen   = len_q;
        gm_mdata  = sel_data;
        gm_mwstrb = sel_strb;
        gm_mid    = AXI_MIDW'(gnt_idx_q);
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      req_saccept[i] = gm_saccept & (state_q != ST_IDLE) & (gnt_idx_q == IDXW'(i));
    end
  end

  // Responses for unknown sids are swallowed so the bridge never stalls.
  always_comb begin
    sid_bad    = (gm_sid >= AXI_MIDW'(NUM_REQ));
    gm_mready  = 1'b1;
    rsp_svalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gm_sid == AXI_MIDW'(i)) begin
        gm_mready     = rsp_mready[i];
        rsp_svalid[i] = gm_svalid;
      end
    end
  end

  assign rsp_sdata = gm_sdata;
  assign rsp_slast = gm_slast;
  assign rsp_sresp = gm_sresp;
  assign err_sid   = err_sid_q;

  assign gm_mburst = GM_BURST_INCR;
  assign gm_mcache = GM_CACHE;
  assign gm_mprot  = GM_PROT;
  assign gm_msize  = GM_SIZE_64;
  assign gm_mlock  = 1'b0;

endmodule
